// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC default,
// NOP encoding, FSM state encoding and the 161-bit commit_info layout.
package fetch_stage_pkg;

   // PC loaded when rst is asserted, unless the instance overrides RESET_PC.
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   // addi x0, x0, 0 -- placed in the slot for a misaligned PC.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // commit_info layout: {valid[160], pc[159:96], instr[95:64], next_pc[63:0]}
   localparam int CI_W           = 161;
   localparam int CI_VALID_BIT   = 160;
   localparam int CI_PC_LSB      = 96;
   localparam int CI_INSTR_LSB   = 64;
   localparam int CI_NEXT_PC_LSB = 0;

   // REQ   : request being presented to instruction memory
   // WAIT  : one request outstanding, its response goes to the slot
   // FLUSH : one request outstanding, its response is thrown away
   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_e;

   // Assemble the commit_info vector from its fields.
   function automatic logic [CI_W-1:0] pack_commit(input logic        valid,
                                                   input logic [63:0] pc,
                                                   input logic [31:0] instr,
                                                   input logic [63:0] next_pc);
      return {valid, pc, instr, next_pc};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
// Handshake: a request transfers on a cycle where imem_o_req_valid and
// imem_i_req_ready are both high; a response transfers on a cycle where
// imem_i_resp_valid and imem_o_resp_ready are both high. The master keeps
// imem_o_req_addr stable while a request is valid and not yet accepted.
interface fetch_stage_if;

   logic        imem_o_req_valid;
   logic [63:0] imem_o_req_addr;
   logic        imem_i_req_ready;
   logic        imem_i_resp_valid;
   logic [31:0] imem_i_resp_data;
   logic        imem_o_resp_ready;

   modport master (
      output imem_o_req_valid,
      output imem_o_req_addr,
      input  imem_i_req_ready,
      input  imem_i_resp_valid,
      input  imem_i_resp_data,
      output imem_o_resp_ready
   );

   modport slave (
      input  imem_o_req_valid,
      input  imem_o_req_addr,
      output imem_i_req_ready,
      output imem_i_resp_valid,
      output imem_i_resp_data,
      input  imem_o_resp_ready
   );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding-request memory
// FSM and a one-entry output slot feeding decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a PC with
// bits [1:0] != 0 issues no memory request and instead places a NOP in the
// slot (next_pc = PC) while the PC holds until a redirect. When undefined the
// low PC bits are simply masked off the request address.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                redirect_i_valid,
   input  logic [63:0]         redirect_i_pc,
   input  logic                stall_i,
   fetch_stage_if.master       imem,
   output logic                fetch_o_valid,
   output logic [63:0]         fetch_o_pc,
   output logic [31:0]         fetch_o_instr,
   output logic [CI_W-1:0]     fetch_o_commit_info,
   output fetch_state_e        dbg_state
);

   fetch_state_e state_q;
   logic [63:0]  pc_q;
   logic [63:0]  next_pc_q;

   logic         misaligned;
   logic         slot_free;
   logic         req_fire;
   logic         resp_fire;
   logic         load_resp;
   logic         load_nop;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misaligned = |pc_q[1:0];
`else
   assign misaligned = 1'b0;
`endif

   // Slot can take a new instruction if empty or being drained this cycle.
   assign slot_free = !fetch_o_valid || !stall_i;

   assign imem.imem_o_req_valid = (state_q == ST_REQ) && !misaligned;
   assign imem.imem_o_req_addr  = {pc_q[63:2], 2'b00};

   // Response acceptance per state. A redirect in WAIT also accepts the
   // response so that a coincident one is really consumed and dropped.
   always_comb begin
      imem.imem_o_resp_ready = 1'b0;
      case (state_q)
         ST_WAIT:  imem.imem_o_resp_ready = slot_free || redirect_i_valid;
         ST_FLUSH: imem.imem_o_resp_ready = 1'b1;
         default:  imem.imem_o_resp_ready = 1'b0;
      endcase
   end

   assign req_fire  = imem.imem_o_req_valid && imem.imem_i_req_ready;
   assign resp_fire = imem.imem_i_resp_valid && imem.imem_o_resp_ready;

   // Redirect always wins over loading the slot.
   assign load_resp = (state_q == ST_WAIT) && resp_fire && !redirect_i_valid;
   assign load_nop  = (state_q == ST_REQ) && misaligned && !redirect_i_valid
                      && slot_free;

   // FSM, PC register and output slot updated together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_REQ;
         pc_q          <= RESET_PC;
         fetch_o_valid <= 1'b0;
         fetch_o_pc    <= 64'd0;
         fetch_o_instr <= 32'd0;
         next_pc_q     <= 64'd0;
      end else begin
         // Output slot.
         if (redirect_i_valid) begin
            fetch_o_valid <= 1'b0;
         end else if (load_resp) begin
            fetch_o_valid <= 1'b1;
            fetch_o_pc    <= pc_q;
            fetch_o_instr <= imem.imem_i_resp_data;
            next_pc_q     <= pc_q + 64'd4;
         end else if (load_nop) begin
            fetch_o_valid <= 1'b1;
            fetch_o_pc    <= pc_q;
            fetch_o_instr <= NOP_INSTR;
            next_pc_q     <= pc_q;
         end else if (fetch_o_valid && !stall_i) begin
            fetch_o_valid <= 1'b0;
         end

         // Request FSM and PC.
         case (state_q)
            ST_REQ: begin
               if (redirect_i_valid) begin
                  pc_q <= redirect_i_pc;
                  // A request accepted this cycle carries the old PC.
                  state_q <= req_fire ? ST_FLUSH : ST_REQ;
               end else if (req_fire) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (redirect_i_valid) begin
                  pc_q    <= redirect_i_pc;
                  state_q <= imem.imem_i_resp_valid ? ST_REQ : ST_FLUSH;
               end else if (resp_fire) begin
                  pc_q    <= pc_q + 64'd4;
                  state_q <= ST_REQ;
               end
            end
            ST_FLUSH: begin
               if (redirect_i_valid) begin
                  pc_q <= redirect_i_pc;
               end
               if (imem.imem_i_resp_valid) begin
                  state_q <= ST_REQ;
               end
            end
            default: begin
               state_q <= ST_REQ;
            end
         endcase
      end
   end

   assign fetch_o_commit_info = pack_commit(fetch_o_valid, fetch_o_pc,
                                            fetch_o_instr, next_pc_q);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory side driven by hand, every
// expected value written out from the intended behaviour.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic          clk;
   logic          rst;
   logic          redirect_i_valid;
   logic [63:0]   redirect_i_pc;
   logic          stall_i;
   logic          fetch_o_valid;
   logic [63:0]   fetch_o_pc;
   logic [31:0]   fetch_o_instr;
   logic [160:0]  fetch_o_commit_info;
   fetch_state_e  dbg_state;

   int checks = 0;
   int errors = 0;

   fetch_stage_if imem ();

   fetch_stage dut (
      .clk                 (clk),
      .rst                 (rst),
      .redirect_i_valid    (redirect_i_valid),
      .redirect_i_pc       (redirect_i_pc),
      .stall_i             (stall_i),
      .imem                (imem.master),
      .fetch_o_valid       (fetch_o_valid),
      .fetch_o_pc          (fetch_o_pc),
      .fetch_o_instr       (fetch_o_instr),
      .fetch_o_commit_info (fetch_o_commit_info),
      .dbg_state           (dbg_state)
   );

   // Clock and time bound.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      #1;
      checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", fetch_o_valid); end
      checks++; if (fetch_o_pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", fetch_o_pc); end
      checks++; if (fetch_o_commit_info !== 161'd0) begin errors++; $display("FAIL reset_commit got %h exp 0", fetch_o_commit_info); end
      checks++; if (imem.imem_o_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid got %0b exp 1", imem.imem_o_req_valid); end
      checks++; if (imem.imem_o_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL reset_req_addr got %h exp 80000000", imem.imem_o_req_addr); end
      checks++; if (dbg_state !== ST_REQ) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_REQ); end
      checks++; if (imem.imem_o_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready got %0b exp 0", imem.imem_o_resp_ready); end
   endtask

   task automatic test_basic();
      logic [160:0] exp_ci;
      exp_ci = {1'b1, 64'h8000_0000, 32'h0000_0093, 64'h8000_0004};
      imem.imem_i_req_ready = 1'b1;
      cyc();
      imem.imem_i_req_ready  = 1'b0;
      imem.imem_i_resp_valid = 1'b1;
      imem.imem_i_resp_data  = 32'h0000_0093;
      #1;
      checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL basic_wait got %0d exp %0d", dbg_state, ST_WAIT); end
      checks++; if (imem.imem_o_resp_ready !== 1'b1) begin errors++; $display("FAIL basic_resp_ready got %0b exp 1", imem.imem_o_resp_ready); end
      cyc();
      imem.imem_i_resp_valid = 1'b0;
      #1;
      checks++; if (fetch_o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", fetch_o_valid); end
      checks++; if (fetch_o_pc !== 64'h8000_0000) begin errors++; $display("FAIL basic_pc got %h exp 80000000", fetch_o_pc); end
      checks++; if (fetch_o_instr !== 32'h0000_0093) begin errors++; $display("FAIL basic_instr got %h exp 00000093", fetch_o_instr); end
      checks++; if (fetch_o_commit_info !== exp_ci) begin errors++; $display("FAIL basic_commit got %h exp %h", fetch_o_commit_info, exp_ci); end
      checks++; if (imem.imem_o_req_addr !== 64'h8000_0004) begin errors++; $display("FAIL basic_next_addr got %h exp 80000004", imem.imem_o_req_addr); end
   endtask

   task automatic test_stall();
      logic [160:0] exp_ci;
      exp_ci = {1'b1, 64'h8000_0000, 32'h0000_0093, 64'h8000_0004};
      stall_i = 1'b1;
      imem.imem_i_req_ready = 1'b1;
      cyc();
      imem.imem_i_req_ready  = 1'b0;
      imem.imem_i_resp_valid = 1'b1;
      imem.imem_i_resp_data  = 32'h0000_0113;
      #1;
      checks++; if (imem.imem_o_resp_ready !== 1'b0) begin errors++; $display("FAIL stall_resp_ready got %0b exp 0", imem.imem_o_resp_ready); end
      checks++; if (fetch_o_commit_info !== exp_ci) begin errors++; $display("FAIL stall_hold1 got %h exp %h", fetch_o_commit_info, exp_ci); end
      cyc();
      checks++; if (fetch_o_commit_info !== exp_ci) begin errors++; $display("FAIL stall_hold2 got %h exp %h", fetch_o_commit_info, exp_ci); end
      checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL stall_state got %0d exp %0d", dbg_state, ST_WAIT); end
      stall_i = 1'b0;
      #1;
      checks++; if (imem.imem_o_resp_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %0b exp 1", imem.imem_o_resp_ready); end
      cyc();
      imem.imem_i_resp_valid = 1'b0;
      exp_ci = {1'b1, 64'h8000_0004, 32'h0000_0113, 64'h8000_0008};
      #1;
      checks++; if (fetch_o_commit_info !== exp_ci) begin errors++; $display("FAIL stall_next got %h exp %h", fetch_o_commit_info, exp_ci); end
      cyc();
      checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %0b exp 0", fetch_o_valid); end
      checks++; if (fetch_o_commit_info[160] !== 1'b0) begin errors++; $display("FAIL stall_ci_valid got %0b exp 0", fetch_o_commit_info[160]); end
   endtask

   task automatic test_redirect_wait();
      imem.imem_i_req_ready = 1'b1;
      cyc();
      imem.imem_i_req_ready = 1'b0;
      redirect_i_valid = 1'b1;
      redirect_i_pc    = 64'h8000_1000;
      cyc();
      redirect_i_valid = 1'b0;
      #1;
      checks++; if (dbg_state !== ST_FLUSH) begin errors++; $display("FAIL rw_flush got %0d exp %0d", dbg_state, ST_FLUSH); end
      checks++; if (imem.imem_o_req_valid !== 1'b0) begin errors++; $display("FAIL rw_req_valid got %0b exp 0", imem.imem_o_req_valid); end
      checks++; if (imem.imem_o_resp_ready !== 1'b1) begin errors++; $display("FAIL rw_resp_ready got %0b exp 1", imem.imem_o_resp_ready); end
      imem.imem_i_resp_valid = 1'b1;
      imem.imem_i_resp_data  = 32'hdead_beef;
      cyc();
      imem.imem_i_resp_valid = 1'b0;
      #1;
      checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_dropped got %0b exp 0", fetch_o_valid); end
      checks++; if (dbg_state !== ST_REQ) begin errors++; $display("FAIL rw_back_req got %0d exp %0d", dbg_state, ST_REQ); end
      checks++; if (imem.imem_o_req_addr !== 64'h8000_1000) begin errors++; $display("FAIL rw_addr got %h exp 80001000", imem.imem_o_req_addr); end
      imem.imem_i_req_ready = 1'b1;
      cyc();
      imem.imem_i_req_ready  = 1'b0;
      imem.imem_i_resp_valid = 1'b1;
      imem.imem_i_resp_data  = 32'h0000_0513;
      cyc();
      imem.imem_i_resp_valid = 1'b0;
      #1;
      checks++; if (fetch_o_pc !== 64'h8000_1000) begin errors++; $display("FAIL rw_out_pc got %h exp 80001000", fetch_o_pc); end
      checks++; if (fetch_o_instr !== 32'h0000_0513) begin errors++; $display("FAIL rw_out_instr got %h exp 00000513", fetch_o_instr); end
   endtask

   task automatic test_redirect_coincident();
      imem.imem_i_req_ready = 1'b1;
      cyc();
      imem.imem_i_req_ready  = 1'b0;
      imem.imem_i_resp_valid = 1'b1;
      imem.imem_i_resp_data  = 32'h0000_0593;
      redirect_i_valid = 1'b1;
      redirect_i_pc    = 64'h8000_1000;
      #1;
      checks++; if (imem.imem_o_resp_ready !== 1'b1) begin errors++; $display("FAIL rc_resp_ready got %0b exp 1", imem.imem_o_resp_ready); end
      cyc();
      imem.imem_i_resp_valid = 1'b0;
      redirect_i_valid = 1'b0;
      #1;
      checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL rc_valid got %0b exp 0", fetch_o_valid); end
      checks++; if (dbg_state !== ST_REQ) begin errors++; $display("FAIL rc_state got %0d exp %0d", dbg_state, ST_REQ); end
      checks++; if (imem.imem_o_req_addr !== 64'h8000_1000) begin errors++; $display("FAIL rc_addr got %h exp 80001000", imem.imem_o_req_addr); end
      cyc();
      checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL rc_no_load got %0b exp 0", fetch_o_valid); end
   endtask

   task automatic test_wrap();
      redirect_i_valid = 1'b1;
      redirect_i_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      cyc();
      redirect_i_valid = 1'b0;
      #1;
      checks++; if (imem.imem_o_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffffffffffc", imem.imem_o_req_addr); end
      imem.imem_i_req_ready = 1'b1;
      cyc();
      imem.imem_i_req_ready  = 1'b0;
      imem.imem_i_resp_valid = 1'b1;
      imem.imem_i_resp_data  = 32'h0000_0013;
      cyc();
      imem.imem_i_resp_valid = 1'b0;
      #1;
      checks++; if (fetch_o_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffffffffffc", fetch_o_pc); end
      checks++; if (fetch_o_commit_info[63:0] !== 64'd0) begin errors++; $display("FAIL wrap_next_pc got %h exp 0", fetch_o_commit_info[63:0]); end
      checks++; if (imem.imem_o_req_addr !== 64'd0) begin errors++; $display("FAIL wrap_next_addr got %h exp 0", imem.imem_o_req_addr); end
   endtask

   task automatic test_reset_mid();
      imem.imem_i_req_ready = 1'b1;
      cyc();
      imem.imem_i_req_ready = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      imem.imem_i_resp_valid = 1'b1;
      imem.imem_i_resp_data  = 32'h0000_0073;
      #1;
      checks++; if (dbg_state !== ST_REQ) begin errors++; $display("FAIL rm_state got %0d exp %0d", dbg_state, ST_REQ); end
      checks++; if (imem.imem_o_resp_ready !== 1'b0) begin errors++; $display("FAIL rm_resp_ready got %0b exp 0", imem.imem_o_resp_ready); end
      checks++; if (imem.imem_o_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL rm_addr got %h exp 80000000", imem.imem_o_req_addr); end
      cyc();
      imem.imem_i_resp_valid = 1'b0;
      checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL rm_no_load got %0b exp 0", fetch_o_valid); end
   endtask

   task automatic test_misalign();
      logic [160:0] exp_ci;
      redirect_i_valid = 1'b1;
      redirect_i_pc    = 64'h8000_0002;
      cyc();
      redirect_i_valid = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_CHECK_EN
      checks++; if (imem.imem_o_req_valid !== 1'b0) begin errors++; $display("FAIL mis_req_valid got %0b exp 0", imem.imem_o_req_valid); end
      cyc();
      exp_ci = {1'b1, 64'h8000_0002, 32'h0000_0013, 64'h8000_0002};
      checks++; if (fetch_o_commit_info !== exp_ci) begin errors++; $display("FAIL mis_slot got %h exp %h", fetch_o_commit_info, exp_ci); end
`else
      exp_ci = 161'd0;
      checks++; if (imem.imem_o_req_valid !== 1'b1) begin errors++; $display("FAIL mis_req_valid got %0b exp 1", imem.imem_o_req_valid); end
      checks++; if (imem.imem_o_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL mis_masked_addr got %h exp 80000000", imem.imem_o_req_addr); end
      checks++; if (fetch_o_commit_info[160] !== exp_ci[160]) begin errors++; $display("FAIL mis_no_slot got %0b exp 0", fetch_o_commit_info[160]); end
`endif
   endtask

   // Test sequence and final report.
   initial begin
      rst = 1'b1;
      redirect_i_valid = 1'b0;
      redirect_i_pc    = 64'd0;
      stall_i          = 1'b0;
      imem.imem_i_req_ready  = 1'b0;
      imem.imem_i_resp_valid = 1'b0;
      imem.imem_i_resp_data  = 32'd0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_redirect_coincident();
      test_wrap();
      test_reset_mid();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 redirect_i_valid  input  1  branch/jump/trap redirect request.
REQ-005 redirect_i_pc  input  64  redirect target PC.
REQ-006 stall_i  input  1  downstream (decode register) cannot accept this cycle.
REQ-007 imem_o_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_o_req_addr  output  64  request address = current PC with bits [1:0] forced to 0.
REQ-009 imem_i_req_ready  input  1  memory accepts request when valid&&ready.
REQ-010 imem_i_resp_valid  input  1  response valid.
REQ-011 imem_i_resp_data  input  32  returned instruction word.
REQ-012 imem_o_resp_ready  output  1  fetch can take response this cycle.
REQ-013 fetch_o_valid  output  1  output slot holds a valid instruction.
REQ-014 fetch_o_pc  output  64  PC of held instruction.
REQ-015 fetch_o_instr  output  32  held instruction.
REQ-016 fetch_o_commit_info  output  161  {valid[160], pc[159:96], instr[95:64], next_pc[63:0]}.

Function
REQ-017 States: REQ (issue request), WAIT (one request outstanding), FLUSH (outstanding response to be discarded); at most one request outstanding at any time.
REQ-018 REQ: imem_o_req_valid=1; on imem_i_req_ready go WAIT, else stay REQ with address stable.
REQ-019 WAIT: imem_o_resp_ready = !fetch_o_valid || !stall_i; response accepted when resp_valid&&resp_ready.
REQ-020 On accepted response: output slot loads {1, pc, data, pc+4} next edge; PC <= PC+4 (64-bit wrap); state <= REQ.
REQ-021 Output slot is cleared (fetch_o_valid<=0) when fetch_o_valid&&!stall_i and no new response loads it the same cycle.
REQ-022 While fetch_o_valid&&stall_i, fetch_o_pc/instr/commit_info hold unchanged.
REQ-023 Best-case latency: request accepted cycle N, response cycle N+1, fetch_o_valid at N+2; throughput 1 instruction / 2 cycles.
REQ-024 Redirect has top priority: PC <= redirect_i_pc; fetch_o_valid <= 0; no response accepted into the slot that cycle.
REQ-025 Redirect in REQ with req_valid&&req_ready same cycle, or in WAIT without a response the same cycle: state <= FLUSH.
REQ-026 Redirect in WAIT coincident with resp_valid: response consumed and dropped; state <= REQ.
REQ-027 Redirect in REQ without handshake: state stays REQ, next request uses new PC.
REQ-028 FLUSH: imem_o_resp_ready=1, imem_o_req_valid=0; on resp_valid discard and go REQ; a further redirect in FLUSH only updates PC.
REQ-029 fetch_o_commit_info[160] equals fetch_o_valid.

Reset
REQ-030 rst: PC <= RESET_PC, state <= REQ, fetch_o_valid <= 0, fetch_o_pc <= 0, fetch_o_instr <= 0, fetch_o_commit_info <= 0.
REQ-031 Reset mid-transaction abandons outstanding request; responses arriving after reset before a new request accepted are discarded (state FLUSH-equivalent not entered; memory side also reset).

Configuration
REQ-032 Macro FETCH_MISALIGN_CHECK_EN: when defined, PC with bits[1:0]!=0 in REQ issues no memory request and loads slot with instr 32'h0000_0013 (NOP), commit next_pc = PC, and PC holds until redirect; when undefined bits[1:0] are silently masked.

Structure
REQ-033 Shared package holds RESET_PC default, NOP encoding, state encoding, commit_info field offsets (161-bit layout).
REQ-034 No sub-module; output slot and PC register in this module.

Verification
REQ-035 Reset, req_ready=1, resp one cycle later with 32'h00000093 -> fetch_o_valid=1, pc=0x80000000, commit_info next_pc=0x80000004.
REQ-036 stall_i=1 with slot full, response pending -> resp_ready=0, outputs unchanged until stall drops, then next instr pc=0x80000004.
REQ-037 Redirect to 0x80001000 while WAIT -> late response dropped, next output pc=0x80001000, no output from stale PC.
REQ-038 Redirect coincident with resp_valid -> response discarded, state REQ, next request addr 0x80001000.
REQ-039 PC=64'hFFFF_FFFF_FFFF_FFFC fetched -> next_pc=0, next request addr 0.
REQ-040 With FETCH_MISALIGN_CHECK_EN, redirect to 0x80000002 -> no imem request, slot instr=0x00000013, pc=0x80000002.
